// File: rtl/rvfi_monitor_pkg.sv
// Shared definitions for the RVFI retirement monitor: error codes and the
// byte-mask legality helper.
package rvfi_monitor_pkg;

    typedef logic [15:0] errcode_t;

    localparam errcode_t ERR_NONE    = 16'h0000;
    localparam errcode_t ERR_ORDER   = 16'h0001;
    localparam errcode_t ERR_PC      = 16'h0002;
    localparam errcode_t ERR_ALIGN   = 16'h0003;
    localparam errcode_t ERR_RS1     = 16'h0004;
    localparam errcode_t ERR_RS2     = 16'h0005;
    localparam errcode_t ERR_RD0     = 16'h0006;
    localparam errcode_t ERR_MEMMASK = 16'h0007;
    localparam errcode_t ERR_TRAP    = 16'h0008;
    localparam errcode_t ERR_HALT    = 16'h0009;

    // A byte mask is legal for a word-aligned access if it selects a byte,
    // an aligned halfword, the whole word, or nothing.
    function automatic logic mask_legal(input logic [3:0] mask);
        logic ok;
        case (mask)
            4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF: ok = 1'b1;
            default:                                         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rvfi_shadow_regfile.sv
// Shadow copy of the architectural integer register file, rebuilt from the
// retirement stream. Entries become valid either by a retired write or by
// learning the value of the first read of a not-yet-known register.
module rvfi_shadow_regfile (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        beat,
    input  logic [4:0]  rs1_addr,
    input  logic [31:0] rs1_rdata,
    input  logic [4:0]  rs2_addr,
    input  logic [31:0] rs2_rdata,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_wdata,
    output logic [31:0] rs1_shadow,
    output logic        rs1_hit,
    output logic [31:0] rs2_shadow,
    output logic        rs2_hit
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] valid_q;
    logic [31:0] valid_d;

    // Combinational read ports expose the pre-update contents; x0 is never
    // marked valid, so its hit is always 0.
    assign rs1_shadow = regs_q[rs1_addr];
    assign rs1_hit    = valid_q[rs1_addr];
    assign rs2_shadow = regs_q[rs2_addr];
    assign rs2_hit    = valid_q[rs2_addr];

    // Next contents: rs2 learn, then rs1 learn (wins when rs1 == rs2), then
    // the retired write, which overrides any learn to the same index.
    always_comb begin
        regs_d  = regs_q;
        valid_d = valid_q;
        if (beat) begin
            if (rs2_addr != 5'd0 && !valid_q[rs2_addr]) begin
                regs_d[rs2_addr]  = rs2_rdata;
                valid_d[rs2_addr] = 1'b1;
            end
            if (rs1_addr != 5'd0 && !valid_q[rs1_addr]) begin
                regs_d[rs1_addr]  = rs1_rdata;
                valid_d[rs1_addr] = 1'b1;
            end
            if (rd_addr != 5'd0) begin
                regs_d[rd_addr]  = rd_wdata;
                valid_d[rd_addr] = 1'b1;
            end
        end
    end

    // Storage and valid bits; reset forgets everything that was learned.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            regs_q  <= regs_d;
        end
    end

endmodule

// File: rtl/rvfi_monitor_rv32imc.sv
// RVFI retirement-stream consistency checker. Each rvfi_valid beat is one
// retired instruction; there is no back-pressure (a valid-only stream: the
// beat is consumed on the posedge where rvfi_valid is 1). The first detected
// violation is latched into errcode and held until reset.
module rvfi_monitor_rv32imc
    import rvfi_monitor_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rvfi_valid,
    input  logic [63:0] rvfi_order,
    input  logic [31:0] rvfi_insn,
    input  logic        rvfi_trap,
    input  logic        rvfi_halt,
    input  logic        rvfi_intr,
    input  logic [1:0]  rvfi_mode,
    input  logic [4:0]  rvfi_rs1_addr,
    input  logic [4:0]  rvfi_rs2_addr,
    input  logic [31:0] rvfi_rs1_rdata,
    input  logic [31:0] rvfi_rs2_rdata,
    input  logic [4:0]  rvfi_rd_addr,
    input  logic [31:0] rvfi_rd_wdata,
    input  logic [31:0] rvfi_pc_rdata,
    input  logic [31:0] rvfi_pc_wdata,
    input  logic [31:0] rvfi_mem_addr,
    input  logic [3:0]  rvfi_mem_rmask,
    input  logic [3:0]  rvfi_mem_wmask,
    input  logic [31:0] rvfi_mem_rdata,
    input  logic [31:0] rvfi_mem_wdata,
    input  logic        rvfi_mem_extamo,
    output logic [15:0] errcode
);

    logic [63:0] order_q, order_d;
    logic [31:0] prev_pc_q, prev_pc_d;
    logic        first_q, first_d;
    logic        halted_q, halted_d;
    errcode_t    errcode_q, errcode_d;

    logic [31:0] rs1_shadow, rs2_shadow;
    logic        rs1_hit, rs2_hit;

    logic        err_order, err_pc, err_align, err_rs1, err_rs2;
    logic        err_rd0, err_memmask, err_trap, err_halt;
    errcode_t    beat_err;

    // Fields that carry no consistency information for this checker.
    logic        unused_inputs;
    assign unused_inputs = ^{rvfi_insn, rvfi_intr, rvfi_mode, rvfi_mem_addr,
                             rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_extamo};

    rvfi_shadow_regfile u_shadow (
        .clock      (clock),
        .reset_n    (reset_n),
        .beat       (rvfi_valid),
        .rs1_addr   (rvfi_rs1_addr),
        .rs1_rdata  (rvfi_rs1_rdata),
        .rs2_addr   (rvfi_rs2_addr),
        .rs2_rdata  (rvfi_rs2_rdata),
        .rd_addr    (rvfi_rd_addr),
        .rd_wdata   (rvfi_rd_wdata),
        .rs1_shadow (rs1_shadow),
        .rs1_hit    (rs1_hit),
        .rs2_shadow (rs2_shadow),
        .rs2_hit    (rs2_hit)
    );

    // Individual checks on the current beat, then lowest-code-first encoding.
    always_comb begin
        err_order   = (rvfi_order != order_q);
        err_pc      = !first_q && (rvfi_pc_rdata != prev_pc_q);
        err_align   = rvfi_pc_rdata[0] || rvfi_pc_wdata[0];
        err_rs1     = (rvfi_rs1_addr == 5'd0) ? (rvfi_rs1_rdata != 32'd0)
                                              : (rs1_hit && rvfi_rs1_rdata != rs1_shadow);
        err_rs2     = (rvfi_rs2_addr == 5'd0) ? (rvfi_rs2_rdata != 32'd0)
                                              : (rs2_hit && rvfi_rs2_rdata != rs2_shadow);
        err_rd0     = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0);
        err_memmask = ((rvfi_mem_rmask != 4'd0) && (rvfi_mem_wmask != 4'd0)) ||
                      !mask_legal(rvfi_mem_rmask) || !mask_legal(rvfi_mem_wmask);
        err_trap    = rvfi_trap;
        err_halt    = halted_q;

        beat_err = ERR_NONE;
        if      (err_order)   beat_err = ERR_ORDER;
        else if (err_pc)      beat_err = ERR_PC;
        else if (err_align)   beat_err = ERR_ALIGN;
        else if (err_rs1)     beat_err = ERR_RS1;
        else if (err_rs2)     beat_err = ERR_RS2;
        else if (err_rd0)     beat_err = ERR_RD0;
        else if (err_memmask) beat_err = ERR_MEMMASK;
        else if (err_trap)    beat_err = ERR_TRAP;
        else if (err_halt)    beat_err = ERR_HALT;
    end

    // Tracking state advances on every beat regardless of its verdict;
    // errcode only captures while it is still clear.
    always_comb begin
        order_d   = order_q;
        prev_pc_d = prev_pc_q;
        first_d   = first_q;
        halted_d  = halted_q || rvfi_halt;
        errcode_d = errcode_q;
        if (rvfi_valid) begin
            order_d   = order_q + 64'd1;
            prev_pc_d = rvfi_pc_wdata;
            first_d   = 1'b0;
            if (errcode_q == ERR_NONE) begin
                errcode_d = beat_err;
            end
        end
    end

    // Monitor state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            order_q   <= '0;
            prev_pc_q <= '0;
            first_q   <= 1'b1;
            halted_q  <= 1'b0;
            errcode_q <= ERR_NONE;
        end else begin
            order_q   <= order_d;
            prev_pc_q <= prev_pc_d;
            first_q   <= first_d;
            halted_q  <= halted_d;
            errcode_q <= errcode_d;
        end
    end

    assign errcode = errcode_q;

endmodule

// File: tb/tb_rvfi_monitor_rv32imc.sv
// Bench for the RVFI retirement monitor: directed scenarios followed by
// randomized rounds of clean beats with one injected fault each.
module tb_rvfi_monitor_rv32imc;

    logic        clock;
    logic        reset_n;
    logic        v_valid;
    logic [63:0] v_order;
    logic [31:0] v_insn;
    logic        v_trap, v_halt, v_intr, v_extamo;
    logic [1:0]  v_mode;
    logic [4:0]  v_rs1, v_rs2, v_rd;
    logic [31:0] v_rs1_rdata, v_rs2_rdata, v_rd_wdata;
    logic [31:0] v_pc_rdata, v_pc_wdata, v_mem_addr, v_mem_rdata, v_mem_wdata;
    logic [3:0]  v_rmask, v_wmask;
    logic [15:0] errcode;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_reg [32];
    bit          m_known [32];
    logic [63:0] m_order;
    logic [31:0] m_prev_pc;
    bit          m_first, m_halted;
    logic [15:0] m_err;

    rvfi_monitor_rv32imc dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .rvfi_valid      (v_valid),
        .rvfi_order      (v_order),
        .rvfi_insn       (v_insn),
        .rvfi_trap       (v_trap),
        .rvfi_halt       (v_halt),
        .rvfi_intr       (v_intr),
        .rvfi_mode       (v_mode),
        .rvfi_rs1_addr   (v_rs1),
        .rvfi_rs2_addr   (v_rs2),
        .rvfi_rs1_rdata  (v_rs1_rdata),
        .rvfi_rs2_rdata  (v_rs2_rdata),
        .rvfi_rd_addr    (v_rd),
        .rvfi_rd_wdata   (v_rd_wdata),
        .rvfi_pc_rdata   (v_pc_rdata),
        .rvfi_pc_wdata   (v_pc_wdata),
        .rvfi_mem_addr   (v_mem_addr),
        .rvfi_mem_rmask  (v_rmask),
        .rvfi_mem_wmask  (v_wmask),
        .rvfi_mem_rdata  (v_mem_rdata),
        .rvfi_mem_wdata  (v_mem_wdata),
        .rvfi_mem_extamo (v_extamo),
        .errcode         (errcode)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_known[i] = 1'b0;
            m_reg[i]   = '0;
        end
        m_order  = '0;
        m_first  = 1'b1;
        m_halted = 1'b0;
        m_err    = 16'h0;
        m_prev_pc = '0;
    endfunction

    // Evaluate the beat currently on the inputs as the DUT sees it at a posedge.
    function automatic void model_edge();
        int codes[$];
        bit bad_rs1, bad_rs2;
        if (!reset_n) return;
        if (v_valid) begin
            bad_rs1 = (v_rs1 == 0) ? (v_rs1_rdata != 0)
                                   : (m_known[v_rs1] && m_reg[v_rs1] != v_rs1_rdata);
            bad_rs2 = (v_rs2 == 0) ? (v_rs2_rdata != 0)
                                   : (m_known[v_rs2] && m_reg[v_rs2] != v_rs2_rdata);
            if (v_order != m_order)                         codes.push_back(1);
            if (!m_first && v_pc_rdata != m_prev_pc)        codes.push_back(2);
            if (v_pc_rdata[0] || v_pc_wdata[0])             codes.push_back(3);
            if (bad_rs1)                                    codes.push_back(4);
            if (bad_rs2)                                    codes.push_back(5);
            if (v_rd == 0 && v_rd_wdata != 0)               codes.push_back(6);
            if ((v_rmask != 0 && v_wmask != 0) ||
                !(v_rmask inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF}) ||
                !(v_wmask inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF}))
                                                            codes.push_back(7);
            if (v_trap)                                     codes.push_back(8);
            if (m_halted)                                   codes.push_back(9);
            if (m_err == 0 && codes.size() > 0) begin
                int lo;
                lo = codes[0];
                foreach (codes[k]) if (codes[k] < lo) lo = codes[k];
                m_err = 16'(lo);
            end
            // Architectural effect: first read of an unknown register teaches
            // its value (rs1 taught first), a write then sets rd.
            if (v_rs1 != 0 && !m_known[v_rs1]) begin
                m_reg[v_rs1] = v_rs1_rdata; m_known[v_rs1] = 1'b1;
            end
            if (v_rs2 != 0 && !m_known[v_rs2]) begin
                m_reg[v_rs2] = v_rs2_rdata; m_known[v_rs2] = 1'b1;
            end
            if (v_rd != 0) begin
                m_reg[v_rd] = v_rd_wdata; m_known[v_rd] = 1'b1;
            end
            m_order   = m_order + 1;
            m_prev_pc = v_pc_wdata;
            m_first   = 1'b0;
        end
        if (v_halt) m_halted = 1'b1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        v_valid = 0; v_order = '0; v_insn = '0; v_trap = 0; v_halt = 0;
        v_intr = 0; v_mode = 2'd3; v_extamo = 0;
        v_rs1 = 0; v_rs2 = 0; v_rd = 0;
        v_rs1_rdata = 0; v_rs2_rdata = 0; v_rd_wdata = 0;
        v_pc_rdata = 0; v_pc_wdata = 0; v_mem_addr = 0;
        v_rmask = 0; v_wmask = 0; v_mem_rdata = 0; v_mem_wdata = 0;
    endtask

    // A beat with no register or memory activity.
    task automatic zero_beat(input logic [63:0] ord, input logic [31:0] pc,
                             input logic [31:0] npc);
        idle_inputs();
        v_valid = 1; v_order = ord; v_pc_rdata = pc; v_pc_wdata = npc;
        v_insn = $urandom;
    endtask

    // A beat that is consistent with everything retired so far.
    task automatic clean_beat();
        logic [3:0] legal [8];
        legal = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
        idle_inputs();
        v_valid = 1;
        v_order = m_order;
        v_insn  = $urandom;
        v_pc_rdata = m_first ? ($urandom & 32'hFFFF_FFFE) : m_prev_pc;
        case ($urandom_range(0, 3))
            0:       v_pc_wdata = $urandom & 32'hFFFF_FFFE;
            1:       v_pc_wdata = v_pc_rdata + 32'd2;
            default: v_pc_wdata = v_pc_rdata + 32'd4;
        endcase
        v_rs1 = 5'($urandom_range(0, 31));
        v_rs2 = 5'($urandom_range(0, 31));
        v_rs1_rdata = (v_rs1 == 0) ? 32'd0 : (m_known[v_rs1] ? m_reg[v_rs1] : $urandom);
        v_rs2_rdata = (v_rs2 == 0) ? 32'd0 : (m_known[v_rs2] ? m_reg[v_rs2] : $urandom);
        if (v_rs2 == v_rs1) v_rs2_rdata = v_rs1_rdata;
        v_rd = 5'($urandom_range(0, 31));
        v_rd_wdata = (v_rd == 0) ? 32'd0 : $urandom;
        case ($urandom_range(0, 2))
            0: v_rmask = legal[$urandom_range(0, 7)];
            1: v_wmask = legal[$urandom_range(0, 7)];
            default: ;
        endcase
        v_mem_addr = $urandom & 32'hFFFF_FFFC;
        v_mem_rdata = $urandom;
        v_mem_wdata = $urandom;
    endtask

    // Present the prepared beat for one edge, then drop valid.
    task automatic send();
        tick();
        v_valid = 0;
    endtask

    task automatic check(input string tag, input logic [15:0] exp);
        checks++;
        assert (errcode === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, errcode, exp);
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        model_reset();
        #1;
        check("in_reset", 16'h0000);
        tick();
        tick();
        reset_n = 1;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        reset_n = 0;
        model_reset();
        #2;
        check("reset_state", 16'h0000);
        tick();
        reset_n = 1;
        tick();
        check("after_reset", 16'h0000);

        // Chained orders and PCs stay clean
        zero_beat(64'd0, 32'h6000_0000, 32'h6000_0004); send(); check("chain0", 16'h0000);
        zero_beat(64'd1, 32'h6000_0004, 32'h6000_0008); send(); check("chain1", 16'h0000);
        zero_beat(64'd2, 32'h6000_0008, 32'h6000_000C); send(); check("chain2", 16'h0000);

        // Order skip, sticky
        do_reset();
        zero_beat(64'd0, 32'h6000_0000, 32'h6000_0004); send();
        zero_beat(64'd1, 32'h6000_0004, 32'h6000_0008); send(); check("order_ok", 16'h0000);
        zero_beat(64'd3, 32'h6000_0008, 32'h6000_000C); send(); check("order_skip", 16'h0001);
        repeat (10) tick();
        check("order_sticky", 16'h0001);

        // Register value mismatch on rs1
        do_reset();
        zero_beat(64'd0, 32'h6000_0000, 32'h6000_0004);
        v_rd = 5'd5; v_rd_wdata = 32'h1234; send(); check("rd_write", 16'h0000);
        zero_beat(64'd1, 32'h6000_0004, 32'h6000_0008);
        v_rs1 = 5'd5; v_rs1_rdata = 32'h1235; send(); check("rs1_mismatch", 16'h0004);

        // PC break
        do_reset();
        zero_beat(64'd0, 32'h6000_000C, 32'h6000_0010); send();
        zero_beat(64'd1, 32'h6000_0014, 32'h6000_0018); send(); check("pc_break", 16'h0002);

        // Two errors on one beat: lowest code wins
        do_reset();
        zero_beat(64'd0, 32'h6000_0000, 32'h6000_0004);
        v_rd_wdata = 32'd1; v_rmask = 4'b0101; send(); check("rd0_over_mask", 16'h0006);

        // Misaligned next PC
        do_reset();
        zero_beat(64'd0, 32'h6000_0000, 32'h6000_0003); send(); check("align", 16'h0003);

        // x0 read returning nonzero on rs2
        do_reset();
        zero_beat(64'd0, 32'h6000_0000, 32'h6000_0002);
        v_rs2_rdata = 32'h8; send(); check("rs2_x0", 16'h0005);

        // Read and write mask together
        do_reset();
        zero_beat(64'd0, 32'h6000_0000, 32'h6000_0004);
        v_rmask = 4'hF; v_wmask = 4'h3; send(); check("mask_both", 16'h0007);

        // Trap
        do_reset();
        zero_beat(64'd0, 32'h6000_0000, 32'h6000_0004);
        v_trap = 1; send(); check("trap", 16'h0008);

        // rd == rs1 compares against the old value
        do_reset();
        zero_beat(64'd0, 32'h6000_0000, 32'h6000_0004);
        v_rd = 5'd7; v_rd_wdata = 32'hAAAA_0001; send();
        zero_beat(64'd1, 32'h6000_0004, 32'h6000_0008);
        v_rs1 = 5'd7; v_rs1_rdata = 32'hAAAA_0001; v_rd = 5'd7; v_rd_wdata = 32'hBBBB_0002;
        send(); check("rd_eq_rs1_old", 16'h0000);
        zero_beat(64'd2, 32'h6000_0008, 32'h6000_000C);
        v_rs1 = 5'd7; v_rs1_rdata = 32'hBBBB_0002; send(); check("rd_eq_rs1_new", 16'h0000);

        // Retirement after halt, then asynchronous reset mid-run
        do_reset();
        zero_beat(64'd0, 32'h6000_0000, 32'h6000_0004); send();
        idle_inputs(); v_halt = 1; tick(); v_halt = 0;
        check("halt_no_beat", 16'h0000);
        zero_beat(64'd1, 32'h6000_0004, 32'h6000_0008); send(); check("post_halt", 16'h0009);
        reset_n = 0;
        model_reset();
        #1;
        check("async_reset", 16'h0000);
        tick();
        reset_n = 1;
        tick();

        // Randomized rounds: clean beats then one injected fault
        for (int r = 0; r < 30; r++) begin
            int n;
            int kind;
            do_reset();
            n = $urandom_range(3, 12);
            for (int b = 0; b < n; b++) begin
                clean_beat();
                send();
                check("rand_clean", m_err);
            end
            kind = $urandom_range(0, 9);
            if (kind == 8) begin
                idle_inputs(); v_halt = 1; tick(); v_halt = 0;
            end
            clean_beat();
            case (kind)
                1: v_order = v_order + 64'd1;
                2: v_pc_rdata = v_pc_rdata ^ 32'h4;
                3: v_pc_wdata = v_pc_wdata | 32'h1;
                4: v_rs1_rdata = v_rs1_rdata ^ (32'h1 << $urandom_range(0, 31));
                5: begin v_rd = 5'd0; v_rd_wdata = $urandom | 32'h1; end
                6: begin v_rmask = 4'h6; end
                7: v_trap = 1;
                9: v_rs2_rdata = v_rs2_rdata ^ (32'h1 << $urandom_range(0, 31));
                default: ;
            endcase
            send();
            check("rand_fault", m_err);
            for (int b = 0; b < 3; b++) begin
                clean_beat();
                send();
                check("rand_after", m_err);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Overall time bound so the run always terminates.
    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

endmodule
